ext_fu_sequencer: RTL and testbench
===================================

Name: ext_fu_sequencer

Overview:
- Sequencer and state holder for the memory-mapped external functional unit (FU) that the decode stage talks to through reserved registers.
- Register writes retiring from WB to x30 (op1), x31 (op2) and x29 (aluop) load operands and launch an operation.
- Store-based reads of x27 (op3) and x26 (csr) return the result and status.
- Runs single-cycle and iterative multi-cycle operations and drives a busy flag back to decode.

Parameters:
- DBITS, 32, operand/datapath width.
- OP3BITS, 31, result width returned on op3; decode sign-extends bit OP3BITS-1.
- ITERS, 32, iteration count for MUL/DIV/REM; must equal DBITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_op1  in  1  WB retiring a write to x30 this cycle
- wr_op2  in  1  WB retiring a write to x31 this cycle
- wr_aluop  in  1  WB retiring a write to x29 this cycle; launches operation
- wr_data  in  DBITS  WB write value (regval)
- rd_op3  in  1  valid SW in decode reading x27 this cycle
- op3  out  OP3BITS  result register
- csr  out  3  status: [0] done, [1] error, [2] overflow
- busy  out  1  operation in progress

Behaviour:
- Reset: state IDLE; op1/op2/aluop registers, op3, csr and busy all 0; any in-flight operation is aborted with no completion.
- States: IDLE, EXEC, DONE.
- Operand writes: wr_op1/wr_op2 load wr_data into op1/op2 at the clock edge, only in IDLE or DONE.
- Launch: wr_aluop in IDLE or DONE latches wr_data[2:0] as the opcode, clears csr to 000 and enters EXEC at the next edge. All writes are evaluated at the same edge; op1/op2 written in the same cycle as aluop are used.
- While busy (EXEC): wr_op1, wr_op2 and wr_aluop are dropped, and the operand registers are unchanged.
- Opcodes:
  - 0 ADD, 1 SUB: 1 EXEC cycle.
  - 2 MUL: signed, low DBITS bits of the product, radix-2 shift-add over operand magnitudes with sign fixup, ITERS EXEC cycles.
  - 3 DIV / 4 REM: signed restoring division on magnitudes, ITERS EXEC cycles. Quotient truncates toward zero; remainder takes the dividend's sign.
  - 5-7: illegal.
- Latency: wr_aluop sampled at edge T gives busy=1 from T to T+N, where N=1 for ADD/SUB and N=ITERS for MUL/DIV/REM. At edge T+N the state becomes DONE, busy=0, csr[0]=1 and op3 is valid.
- Illegal opcode and divide-by-zero complete after 1 EXEC cycle with csr=3'b011.
  - Divide-by-zero: op3 = all ones for DIV, op1[OP3BITS-1:0] for REM.
  - Illegal opcode: op3=0.
- Overflow: csr[2]=1 when the full DBITS-bit result lies outside [-2^(OP3BITS-1), 2^(OP3BITS-1)-1]; op3 then holds result[OP3BITS-1:0].
- MUL also sets csr[2] if the true product exceeds DBITS bits signed.
- ADD/SUB wrap at DBITS before the range check.
- op3 and csr hold their values in DONE until the next launch.
- rd_op3 in DONE clears csr[0] and returns to IDLE at the next edge; op3 and csr[2:1] are retained.
- If rd_op3 and wr_aluop occur in the same cycle in DONE, the launch wins: state goes to EXEC and csr clears.
- rd_op3 in IDLE or EXEC has no effect.
- busy is a registered output, asserted exactly while state==EXEC.

Optional Feature:
- Macro FU_EARLY_TERM_EN.
- Defined:
  - MUL enters DONE on the edge after the remaining multiplier magnitude bits become all zero; minimum 1 EXEC cycle, and 0*x completes in 1 cycle.
  - DIV/REM skip leading-zero dividend iterations, with the count computed at launch; minimum 1 EXEC cycle.
  - Results and csr are identical to the non-early-termination case.
- Undefined: fixed N=ITERS for MUL/DIV/REM.

Test Plan:
- MUL: wr op1=7, op2=0xFFFFFFFD, aluop=2 → busy high exactly 32 cycles, then op3=0x7FFFFFEB, csr=3'b001.
- DIV then REM:
  - op1=100, op2=-7, aluop=3 → op3=0x7FFFFFF2 (-14), csr=001.
  - rd_op3 → csr=000, state IDLE.
  - aluop=4 → op3=2.
- Divide-by-zero: op1=5, op2=0, aluop=3 → 1 EXEC cycle, op3=0x7FFFFFFF, csr=3'b011. Illegal aluop=6 → op3=0, csr=011.
- Overflow: op1=0x3FFFFFFF, op2=1, aluop=0 → op3=0x40000000, csr=3'b101.
- Busy and reset:
  - During MUL, wr_op1=9 and wr_aluop=0 at cycle 5 → ignored; result still 7*-3.
  - A second MUL with reset asserted at cycle 10 → busy=0, op3=0, csr=0 next edge, no completion afterwards.
- Simultaneous events: in DONE, rd_op3 and wr_aluop=1 (op1=3, op2=5) together → EXEC, csr=000, then op3=0x7FFFFFFE, csr=001.

Source files
------------

// File: rtl/ext_fu_if.sv
// Bundle of the WB/decode-side signals that talk to the external functional unit.
// master = pipeline side (writes operands, reads result); slave = the FU sequencer.
interface ext_fu_if #(
    parameter int DBITS   = 32,
    parameter int OP3BITS = 31
) ();
    logic               wr_op1;
    logic               wr_op2;
    logic               wr_aluop;
    logic [DBITS-1:0]   wr_data;
    logic               rd_op3;
    logic [OP3BITS-1:0] op3;
    logic [2:0]         csr;
    logic               busy;

    modport master (
        output wr_op1, wr_op2, wr_aluop, wr_data, rd_op3,
        input  op3, csr, busy
    );

    modport slave (
        input  wr_op1, wr_op2, wr_aluop, wr_data, rd_op3,
        output op3, csr, busy
    );
endinterface

// File: rtl/ext_fu_sequencer.sv
// Sequencer/state holder for the external FU: ADD/SUB, iterative signed MUL/DIV/REM, status in csr.
// Define FU_EARLY_TERM_EN to let MUL/DIV/REM stop once the remaining magnitude bits are exhausted.
module ext_fu_sequencer #(
    parameter int DBITS   = 32,
    parameter int OP3BITS = 31,
    parameter int ITERS   = 32
) (
    input logic     clk,
    input logic     reset,
    ext_fu_if.slave fu
);
    localparam int CW = $clog2(ITERS + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;

    logic [DBITS-1:0]   op1, op2;
    logic [2:0]         aluop;
    logic [OP3BITS-1:0] op3_r;
    logic [2:0]         csr_r;
    logic               busy_r;
    logic [CW-1:0]      cnt;
    // MUL: acc = product, breg = shifting multiplicand, qreg = remaining multiplier.
    // DIV/REM: acc = partial remainder, breg = divisor, qreg = dividend shifting into quotient.
    logic [2*DBITS-1:0] acc, breg;
    logic [DBITS-1:0]   qreg;

    logic [DBITS-1:0]   op1_eff, op2_eff, mag1_eff, mag2_eff, dvd_init;
    logic [CW-1:0]      cnt_init;
    logic [2*DBITS-1:0] acc_step, breg_step, prod_s;
    logic [DBITS-1:0]   qreg_step, result;
    logic [DBITS:0]     div_shift;
    logic               div_ge, neg, mul_ovf, range_ovf, illegal, div_zero, single, last;
    logic               launch, finish;
    logic [OP3BITS-1:0] op3_nxt;
    logic [2:0]         csr_nxt;

    // Operand magnitudes as seen at the launch edge, including same-cycle operand writes.
    always_comb begin
        op1_eff  = fu.wr_op1 ? fu.wr_data : op1;
        op2_eff  = fu.wr_op2 ? fu.wr_data : op2;
        mag1_eff = op1_eff[DBITS-1] ? -op1_eff : op1_eff;
        mag2_eff = op2_eff[DBITS-1] ? -op2_eff : op2_eff;
`ifdef FU_EARLY_TERM_EN
        begin
            logic [CW-1:0] lz;
            logic          found;
            lz    = '0;
            found = 1'b0;
            for (int i = DBITS - 1; i >= 0; i--) begin
                if (!found) begin
                    if (mag1_eff[i]) found = 1'b1;
                    else             lz = lz + CW'(1);
                end
            end
            if (lz == CW'(ITERS)) lz = CW'(ITERS - 1);
            dvd_init = mag1_eff << lz;
            cnt_init = (fu.wr_data[2:0] == OP_MUL) ? CW'(ITERS - 1) : CW'(ITERS - 1) - lz;
        end
`else
        dvd_init = mag1_eff;
        cnt_init = CW'(ITERS - 1);
`endif
    end

    // One iteration step plus the result/status that would be committed if this is the last step.
    always_comb begin
        div_shift = {acc[DBITS-1:0], qreg[DBITS-1]};
        div_ge    = div_shift >= {1'b0, breg[DBITS-1:0]};
        if (aluop == OP_MUL) begin
            acc_step  = qreg[0] ? acc + breg : acc;
            breg_step = breg << 1;
            qreg_step = qreg >> 1;
        end else begin
            acc_step  = (2*DBITS)'(div_ge ? div_shift - {1'b0, breg[DBITS-1:0]} : div_shift);
            breg_step = breg;
            qreg_step = {qreg[DBITS-2:0], div_ge};
        end

        neg      = op1[DBITS-1] ^ op2[DBITS-1];
        prod_s   = neg ? -acc_step : acc_step;
        illegal  = aluop > OP_REM;
        div_zero = ((aluop == OP_DIV) || (aluop == OP_REM)) && (op2 == '0);
        single   = illegal || div_zero || (aluop == OP_ADD) || (aluop == OP_SUB);
        mul_ovf  = 1'b0;
        case (aluop)
            OP_ADD:  result = op1 + op2;
            OP_SUB:  result = op1 - op2;
            OP_MUL: begin
                result  = prod_s[DBITS-1:0];
                mul_ovf = prod_s[2*DBITS-1:DBITS-1] != {(DBITS+1){prod_s[DBITS-1]}};
            end
            OP_DIV:  result = neg ? -qreg_step : qreg_step;
            OP_REM:  result = op1[DBITS-1] ? -acc_step[DBITS-1:0] : acc_step[DBITS-1:0];
            default: result = '0;
        endcase
        range_ovf = result[DBITS-1:OP3BITS-1] != {(DBITS-OP3BITS+1){result[OP3BITS-1]}};

        if (illegal) begin
            op3_nxt = '0;
            csr_nxt = 3'b011;
        end else if (div_zero) begin
            op3_nxt = (aluop == OP_DIV) ? '1 : op1[OP3BITS-1:0];
            csr_nxt = 3'b011;
        end else begin
            op3_nxt = result[OP3BITS-1:0];
            csr_nxt = {range_ovf | mul_ovf, 2'b01};
        end

`ifdef FU_EARLY_TERM_EN
        last = single || (cnt == '0) || ((aluop == OP_MUL) && (qreg_step == '0));
`else
        last = single || (cnt == '0);
`endif
    end

    // Next-state: a launch in DONE takes priority over a concurrent result read.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (fu.wr_aluop) begin
                    launch    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (fu.wr_aluop) begin
                    launch    = 1'b1;
                    state_nxt = EXEC;
                end else if (fu.rd_op3) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            op1    <= '0;
            op2    <= '0;
            aluop  <= '0;
            op3_r  <= '0;
            csr_r  <= '0;
            cnt    <= '0;
            acc    <= '0;
            breg   <= '0;
            qreg   <= '0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt == EXEC);
            if (state != EXEC) begin
                if (fu.wr_op1) op1 <= fu.wr_data;
                if (fu.wr_op2) op2 <= fu.wr_data;
            end
            if (launch) begin
                aluop <= fu.wr_data[2:0];
                csr_r <= 3'b000;
                cnt   <= cnt_init;
                acc   <= '0;
                if (fu.wr_data[2:0] == OP_MUL) begin
                    breg <= {{DBITS{1'b0}}, mag1_eff};
                    qreg <= mag2_eff;
                end else begin
                    breg <= {{DBITS{1'b0}}, mag2_eff};
                    qreg <= dvd_init;
                end
            end else if (state == EXEC) begin
                acc  <= acc_step;
                breg <= breg_step;
                qreg <= qreg_step;
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (finish) begin
                    op3_r <= op3_nxt;
                    csr_r <= csr_nxt;
                end
            end else if ((state == DONE) && fu.rd_op3) begin
                csr_r[0] <= 1'b0;
            end
        end
    end

    assign fu.op3  = op3_r;
    assign fu.csr  = csr_r;
    assign fu.busy = busy_r;
endmodule

// File: tb/tb_ext_fu_sequencer.sv
// Directed self-checking bench for ext_fu_sequencer (default build, fixed-latency MUL/DIV/REM).
module tb_ext_fu_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;

    ext_fu_if #(.DBITS(32), .OP3BITS(31)) fu_bus ();

    ext_fu_sequencer #(.DBITS(32), .OP3BITS(31), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .fu    (fu_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of WB/decode activity, then return all strobes to idle.
    task automatic applyStimulus(input logic w1, input logic w2, input logic wa,
                                 input logic rd, input logic [31:0] data);
        fu_bus.wr_op1   = w1;
        fu_bus.wr_op2   = w2;
        fu_bus.wr_aluop = wa;
        fu_bus.rd_op3   = rd;
        fu_bus.wr_data  = data;
        tick();
        fu_bus.wr_op1   = 1'b0;
        fu_bus.wr_op2   = 1'b0;
        fu_bus.wr_aluop = 1'b0;
        fu_bus.rd_op3   = 1'b0;
        fu_bus.wr_data  = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Counts busy cycles after a launch; injectAt>0 fires an ignored op1/aluop write on that cycle.
    task automatic waitDone(input int injectAt, output int cycles);
        cycles = 0;
        while (fu_bus.busy && cycles < 200) begin
            cycles++;
            if (cycles == injectAt) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd9);
            else                    tick();
        end
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output int cycles);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, a);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, b);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, {29'd0, op});
        waitDone(0, cycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset           = 1'b1;
        fu_bus.wr_op1   = 1'b0;
        fu_bus.wr_op2   = 1'b0;
        fu_bus.wr_aluop = 1'b0;
        fu_bus.rd_op3   = 1'b0;
        fu_bus.wr_data  = '0;
        repeat (2) tick();
        checkOutput("reset_busy", {31'd0, fu_bus.busy}, 32'd0);
        checkOutput("reset_op3", {1'b0, fu_bus.op3}, 32'd0);
        checkOutput("reset_csr", {29'd0, fu_bus.csr}, 32'd0);
        reset = 1'b0;
        tick();

        // 7 * -3 with dropped writes on busy cycle 5
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
        checkOutput("mul_busy_start", {31'd0, fu_bus.busy}, 32'd1);
        waitDone(5, cyc);
        checkOutput("mul_cycles", cyc, 32'd32);
        checkOutput("mul_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFEB);
        checkOutput("mul_csr", {29'd0, fu_bus.csr}, 32'd1);

        runOp(32'd100, 32'hFFFF_FFF9, 3'd3, cyc);
        checkOutput("div_cycles", cyc, 32'd32);
        checkOutput("div_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFF2);
        checkOutput("div_csr", {29'd0, fu_bus.csr}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        checkOutput("read_csr", {29'd0, fu_bus.csr}, 32'd0);
        checkOutput("read_op3_kept", {1'b0, fu_bus.op3}, 32'h7FFF_FFF2);
        checkOutput("read_busy", {31'd0, fu_bus.busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd4);
        waitDone(0, cyc);
        checkOutput("rem_op3", {1'b0, fu_bus.op3}, 32'd2);
        checkOutput("rem_csr", {29'd0, fu_bus.csr}, 32'd1);

        runOp(32'hFFFF_FFF9, 32'd2, 3'd3, cyc);
        checkOutput("div_neg_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFFD);
        runOp(32'hFFFF_FFF9, 32'd2, 3'd4, cyc);
        checkOutput("rem_neg_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFFF);

        runOp(32'd5, 32'd0, 3'd3, cyc);
        checkOutput("divz_cycles", cyc, 32'd1);
        checkOutput("divz_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFFF);
        checkOutput("divz_csr", {29'd0, fu_bus.csr}, 32'd3);
        runOp(32'd5, 32'd0, 3'd4, cyc);
        checkOutput("remz_op3", {1'b0, fu_bus.op3}, 32'd5);
        checkOutput("remz_csr", {29'd0, fu_bus.csr}, 32'd3);
        runOp(32'd5, 32'd1, 3'd6, cyc);
        checkOutput("illegal_cycles", cyc, 32'd1);
        checkOutput("illegal_op3", {1'b0, fu_bus.op3}, 32'd0);
        checkOutput("illegal_csr", {29'd0, fu_bus.csr}, 32'd3);

        runOp(32'h3FFF_FFFF, 32'd1, 3'd0, cyc);
        checkOutput("add_ovf_cycles", cyc, 32'd1);
        checkOutput("add_ovf_op3", {1'b0, fu_bus.op3}, 32'h4000_0000);
        checkOutput("add_ovf_csr", {29'd0, fu_bus.csr}, 32'd5);
        runOp(32'h0001_0000, 32'h0001_0000, 3'd2, cyc);
        checkOutput("mul_ovf_op3", {1'b0, fu_bus.op3}, 32'd0);
        checkOutput("mul_ovf_csr", {29'd0, fu_bus.csr}, 32'd5);

        // Launch and read together in DONE: launch wins
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd1);
        checkOutput("simul_busy", {31'd0, fu_bus.busy}, 32'd1);
        checkOutput("simul_csr", {29'd0, fu_bus.csr}, 32'd0);
        waitDone(0, cyc);
        checkOutput("sub_op3", {1'b0, fu_bus.op3}, 32'h7FFF_FFFE);
        checkOutput("sub_csr", {29'd0, fu_bus.csr}, 32'd1);

        // Reset in the middle of a MUL aborts it
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
        repeat (9) tick();
        checkOutput("mul2_busy_mid", {31'd0, fu_bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, fu_bus.busy}, 32'd0);
        checkOutput("abort_op3", {1'b0, fu_bus.op3}, 32'd0);
        checkOutput("abort_csr", {29'd0, fu_bus.csr}, 32'd0);
        repeat (40) tick();
        checkOutput("abort_no_done_csr", {29'd0, fu_bus.csr}, 32'd0);
        checkOutput("abort_no_done_busy", {31'd0, fu_bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
